nlm_norm_div: RTL and testbench

- Terminal stage after the last PE of the NLM denoise chain.
- Consumes the accumulated pixel-weighted sum and weight sum.
- Produces the normalised denoised pixel, pix_sum / weight_sum, rounded to DATA_WIDTH bits.
- Sequential radix-2 restoring divider with fixed latency and valid/ready on both sides; a tag (pixel coordinate) travels alongside.

---
 rtl/nlm_pkg.sv | 28 ++
 rtl/nlm_div_step.sv | 20 ++
 rtl/nlm_norm_div.sv | 129 ++++++++++++
 tb/tb_nlm_norm_div.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/nlm_pkg.sv
// Shared NLM chain definitions: weight width, window/sum width derivations and
// the normaliser FSM state type. Used by the PE chain and nlm_norm_div alike.
package nlm_pkg;

   localparam int unsigned NLM_WEIGHT_WIDTH = 8;

   function automatic int unsigned win_size(input int unsigned srh_length);
      return ((srh_length + 1) / 2) * ((srh_length + 1) / 2);
   endfunction

   function automatic int unsigned weight_sum_width(input int unsigned weight_width,
                                                    input int unsigned srh_length);
      return weight_width + int'($clog2(win_size(srh_length)));
   endfunction

   function automatic int unsigned pix_sum_width(input int unsigned data_width,
                                                 input int unsigned weight_width,
                                                 input int unsigned srh_length);
      return weight_sum_width(weight_width, srh_length) + data_width;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DIV,
      ST_DONE
   } nlm_state_e;

endpackage

// File: rtl/nlm_div_step.sv
// One restoring-division step: subtract the pre-shifted divisor from the
// partial remainder and keep the difference only when it is non-negative.
module nlm_div_step #(
   parameter int unsigned WIDTH = 27
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] divisor_sh,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   logic [WIDTH:0] trial;

   always_comb begin
      trial    = {1'b0, rem} - {1'b0, divisor_sh};
      q_bit    = ~trial[WIDTH];
      rem_next = q_bit ? trial[WIDTH-1:0] : rem;
   end

endmodule

// File: rtl/nlm_norm_div.sv
// Terminal NLM stage: pix_sum / weight_sum via a fixed-latency radix-2 restoring
// divider. Define NLM_NORM_ROUND_EN for round-half-up; default build truncates.
module nlm_norm_div
   import nlm_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH       = 12,
   parameter  int unsigned SRH_LENGTH       = 13,
   parameter  int unsigned WEIGHT_WIDTH     = NLM_WEIGHT_WIDTH,
   parameter  int unsigned TAG_WIDTH        = 16,
   localparam int unsigned WEIGHT_SUM_WIDTH = weight_sum_width(WEIGHT_WIDTH, SRH_LENGTH),
   localparam int unsigned PIX_SUM_WIDTH    = pix_sum_width(DATA_WIDTH, WEIGHT_WIDTH, SRH_LENGTH)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [PIX_SUM_WIDTH-1:0]    pix_sum_i,
   input  logic [WEIGHT_SUM_WIDTH-1:0] weight_sum_i,
   input  logic [TAG_WIDTH-1:0]        tag_i,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_WIDTH-1:0]       pix_o,
   output logic [TAG_WIDTH-1:0]        tag_o,
   output logic                        sat_o,
   output logic                        div0_o
);

   localparam int unsigned DVD_W = PIX_SUM_WIDTH + 1;
   localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   nlm_state_e                  state, state_next;
   logic [CNT_W-1:0]            cnt;
   logic [DVD_W-1:0]            rem, rem_next, dividend, sat_thr, divisor_sh;
   logic [WEIGHT_SUM_WIDTH-1:0] divisor;
   logic [DATA_WIDTH-1:0]       quot, quot_fin;
   logic [TAG_WIDTH-1:0]        tag_q;
   logic                        sat_q, div0_q, q_bit;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = ST_DIV;
         end
         ST_DIV: begin
            if (cnt == '0) state_next = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
`ifdef NLM_NORM_ROUND_EN
      dividend = DVD_W'(pix_sum_i) + DVD_W'(weight_sum_i >> 1);
`else
      dividend = DVD_W'(pix_sum_i);
`endif
      sat_thr    = DVD_W'(weight_sum_i) << DATA_WIDTH;
      divisor_sh = DVD_W'(divisor) << cnt;
      quot_fin   = {quot[DATA_WIDTH-2:0], q_bit};
   end

   nlm_div_step #(.WIDTH(DVD_W)) u_step (
      .rem        (rem),
      .divisor_sh (divisor_sh),
      .rem_next   (rem_next),
      .q_bit      (q_bit)
   );

   // Results are committed to the output registers only on the last DIV step,
   // so a reset mid-operation leaves them at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt     <= '0;
         rem     <= '0;
         quot    <= '0;
         divisor <= '0;
         tag_q   <= '0;
         sat_q   <= 1'b0;
         div0_q  <= 1'b0;
         pix_o   <= '0;
         tag_o   <= '0;
         sat_o   <= 1'b0;
         div0_o  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  rem     <= dividend;
                  divisor <= weight_sum_i;
                  tag_q   <= tag_i;
                  sat_q   <= (dividend >= sat_thr);
                  div0_q  <= (weight_sum_i == '0);
                  quot    <= '0;
                  cnt     <= CNT_W'(DATA_WIDTH - 1);
               end
            end
            ST_DIV: begin
               rem  <= rem_next;
               quot <= quot_fin;
               if (cnt == '0) begin
                  tag_o  <= tag_q;
                  div0_o <= div0_q;
                  sat_o  <= sat_q & ~div0_q;
                  if (div0_q)     pix_o <= '0;
                  else if (sat_q) pix_o <= '1;
                  else            pix_o <= quot_fin;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nlm_norm_div.sv
// Randomised self-checking bench for nlm_norm_div against a plain-division
// reference model; follows NLM_NORM_ROUND_EN in the same way as the RTL.
module tb_nlm_norm_div;

   localparam int unsigned DW  = 12;
   localparam int unsigned PSW = 26;
   localparam int unsigned WSW = 14;
   localparam int unsigned TW  = 16;

   typedef struct {
      logic [DW-1:0] pix;
      logic          sat;
      logic          div0;
   } res_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [PSW-1:0] pix_sum_i;
   logic [WSW-1:0] weight_sum_i;
   logic [TW-1:0]  tag_i;
   logic           out_valid;
   logic           out_ready;
   logic [DW-1:0]  pix_o;
   logic [TW-1:0]  tag_o;
   logic           sat_o;
   logic           div0_o;

   int n_checks = 0;
   int n_errors = 0;

   nlm_norm_div #(
      .DATA_WIDTH   (12),
      .SRH_LENGTH   (13),
      .WEIGHT_WIDTH (8),
      .TAG_WIDTH    (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .pix_sum_i    (pix_sum_i),
      .weight_sum_i (weight_sum_i),
      .tag_i        (tag_i),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .pix_o        (pix_o),
      .tag_o        (tag_o),
      .sat_o        (sat_o),
      .div0_o       (div0_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: round/truncate, divide, then clamp to the output range.
   function automatic res_t ref_div(input longint unsigned ps, input longint unsigned ws);
      res_t r;
      longint unsigned dvd, q;
      dvd = ps;
`ifdef NLM_NORM_ROUND_EN
      dvd = ps + ws / 2;
`endif
      if (ws == 0) begin
         r.pix = '0; r.sat = 1'b0; r.div0 = 1'b1;
      end else begin
         q = dvd / ws;
         r.div0 = 1'b0;
         if (q > 4095) begin
            r.pix = 12'd4095; r.sat = 1'b1;
         end else begin
            r.pix = q[DW-1:0]; r.sat = 1'b0;
         end
      end
      return r;
   endfunction

   task automatic send(input logic [PSW-1:0] ps, input logic [WSW-1:0] ws, input logic [TW-1:0] tg);
      int n = 0;
      while (!in_ready && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      check("in_ready_before_send", in_ready, 1);
      pix_sum_i    = ps;
      weight_sum_i = ws;
      tag_i        = tg;
      in_valid     = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Called one step after the accept edge, i.e. in cycle 1 of the operation.
   task automatic collect(input res_t exp, input logic [TW-1:0] exp_tag, input int stall);
      int cyc = 1;
      out_ready = (stall == 0);
      while (!out_valid && cyc < 64) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("latency", cyc, 13);
      check("pix_o", pix_o, exp.pix);
      check("tag_o", tag_o, exp_tag);
      check("sat_o", sat_o, exp.sat);
      check("div0_o", div0_o, exp.div0);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         check("hold_out_valid", out_valid, 1);
         check("hold_in_ready", in_ready, 0);
         check("hold_pix_o", pix_o, exp.pix);
         check("hold_tag_o", tag_o, exp_tag);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("xfer_out_valid", out_valid, 0);
      check("xfer_in_ready", in_ready, 1);
   endtask

   task automatic run_op(input logic [PSW-1:0] ps, input logic [WSW-1:0] ws,
                         input logic [TW-1:0] tg, input int stall);
      send(ps, ws, tg);
      collect(ref_div(ps, ws), tg, stall);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [PSW-1:0] ps;
      logic [WSW-1:0] ws;
      int             sel;
      logic           seen;

      rst_n        = 1'b0;
      in_valid     = 1'b0;
      out_ready    = 1'b1;
      pix_sum_i    = '0;
      weight_sum_i = '0;
      tag_i        = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_pix_o", pix_o, 0);
      check("rst_tag_o", tag_o, 0);
      check("rst_sat_o", sat_o, 0);
      check("rst_div0_o", div0_o, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(26'd490000, 14'd490, 16'h1234, 0);
      run_op(26'd7, 14'd2, 16'h0007, 0);
      run_op(26'd5, 14'd3, 16'h0005, 0);
      run_op(26'd100, 14'd0, 16'hd1f0, 0);
      run_op(26'h2000000, 14'd1, 16'h5a75, 0);
      run_op(26'h3ffffff, 14'h3fff, 16'hffff, 0);

      // Backpressure: a second operand presented during DIV/DONE must wait.
      send(26'd123456, 14'd789, 16'haaaa);
      pix_sum_i    = 26'd40000;
      weight_sum_i = 14'd100;
      tag_i        = 16'hbbbb;
      in_valid     = 1'b1;
      collect(ref_div(26'd123456, 14'd789), 16'haaaa, 5);
      @(posedge clk); #1;
      in_valid = 1'b0;
      collect(ref_div(26'd40000, 14'd100), 16'hbbbb, 0);

      // Reset in cycle 6 of DIV abandons the operation.
      send(26'd300000, 14'd300, 16'hcccc);
      repeat (5) @(posedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("midrst_in_ready", in_ready, 1);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_pix_o", pix_o, 0);
      check("midrst_tag_o", tag_o, 0);
      check("midrst_sat_o", sat_o, 0);
      check("midrst_div0_o", div0_o, 0);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      check("midrst_no_output", seen, 0);
      run_op(26'd999999, 14'd1000, 16'h0bad, 0);

      for (int k = 0; k < 40; k++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0) begin
            ws = '0;
            ps = PSW'($urandom);
         end else if (sel == 1) begin
            ws = WSW'($urandom_range(1, 15));
            ps = PSW'($urandom) | 26'h2000000;
         end else begin
            ws = WSW'($urandom_range(1, 16383));
            ps = PSW'(ws * $urandom_range(0, 4095) + $urandom_range(0, ws - 1));
         end
         run_op(ps, ws, TW'($urandom), $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
